// File: rtl/dso_cmd_pkg.sv
// Shared types and constants for the DSO host command path.
//   rx_state_t   : command framer receive states
//   tx_state_t   : response transmit states
//   opcodes, ACK : command byte values exchanged with the host
package dso_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        B1,
        B2,
        FULL
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT
    } tx_state_t;

    localparam logic [7:0] DUMP_CH  = 8'h01;
    localparam logic [7:0] CFG_GAIN = 8'h02;
    localparam logic [7:0] TRIG_LVL = 8'h03;
    localparam logic [7:0] TRIG_POS = 8'h04;
    localparam logic [7:0] SET_DEC  = 8'h05;
    localparam logic [7:0] TRIG_CFG = 8'h06;
    localparam logic [7:0] TRIG_RD  = 8'h07;
    localparam logic [7:0] EEP_WRT  = 8'h08;
    localparam logic [7:0] EEP_RD   = 8'h09;

    localparam logic [7:0] ACK      = 8'hA5;

    // True when the byte is one of the opcodes the dispatcher understands.
    function automatic logic opcode_known(input logic [7:0] op);
        return (op == DUMP_CH)  || (op == CFG_GAIN) || (op == TRIG_LVL) ||
               (op == TRIG_POS) || (op == SET_DEC)  || (op == TRIG_CFG) ||
               (op == TRIG_RD)  || (op == EEP_WRT)  || (op == EEP_RD);
    endfunction

endpackage

// File: rtl/resp_tx_ctrl.sv
// Response transmit sequencer: latches one response byte and drives the
// UART transmitter start/done handshake.
//   clk, rst       : clock, async active-high reset
//   resp_data      : byte to send (latched on accepted send_resp)
//   send_resp      : one-cycle send request, dropped while busy
//   tx_data        : byte presented to the UART transmitter
//   trmt           : one-cycle transmit start pulse
//   tx_done        : UART transmitter finished (level)
//   resp_busy      : response in flight
//   resp_sent      : one-cycle pulse when the byte is finished
module resp_tx_ctrl
    import dso_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] resp_data,
    input  logic       send_resp,
    output logic [7:0] tx_data,
    output logic       trmt,
    input  logic       tx_done,
    output logic       resp_busy,
    output logic       resp_sent
);

    tx_state_t  state_q;
    logic [7:0] tx_data_q;
    logic       trmt_q;
    logic       busy_q;
    logic       sent_q;
    logic       first_q;   // first TX_WAIT cycle: tx_done may still show the previous frame

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            tx_data_q <= 8'h00;
            trmt_q    <= 1'b0;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            trmt_q <= 1'b0;
            sent_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_data_q <= resp_data;
                        busy_q    <= 1'b1;
                        state_q   <= TX_START;
                    end
                end
                TX_START: begin
                    trmt_q  <= 1'b1;
                    first_q <= 1'b1;
                    state_q <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (first_q) begin
                        first_q <= 1'b0;
                    end else if (tx_done) begin
                        sent_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= TX_IDLE;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign trmt      = trmt_q;
    assign resp_busy = busy_q;
    assign resp_sent = sent_q;

endmodule

// File: rtl/uart_cmd_frm.sv
// Host command framer: packs three UART bytes into a 24-bit command held
// under a ready/clear handshake, and sequences single-byte responses.
// A partial frame idle for TO_CYCLES clocks is dropped (frame_err pulse).
//   clk, rst            : clock, async active-high reset
//   rx_data, rx_rdy     : byte from UART receiver, rdy is a level
//   rx_clr_rdy          : one-cycle acknowledge of rx_data
//   cmd, cmd_rdy        : assembled command (first byte in [23:16]) and valid level
//   clr_cmd_rdy         : dispatcher consumed cmd
//   resp_data, send_resp: response byte and send request
//   tx_data, trmt       : byte and start pulse to the UART transmitter
//   tx_done             : UART transmitter finished
//   resp_busy, resp_sent: response in flight / finished pulse
//   frame_err           : partial frame dropped on timeout
module uart_cmd_frm
    import dso_cmd_pkg::*;
#(
    parameter int TO_CYCLES = 65536,
    parameter int TO_W      = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        rx_clr_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp_data,
    input  logic        send_resp,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    output logic        resp_busy,
    output logic        resp_sent,
    output logic        frame_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    rx_state_t        state_q;
    logic [23:0]      cmd_q;
    logic             cmd_rdy_q;
    logic             rx_clr_rdy_q;
    logic             frame_err_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             accept;

    // While our acknowledge is out the UART has not yet dropped rdy; ignore
    // that cycle so the same byte is not taken twice.
    assign accept = rx_rdy & ~rx_clr_rdy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= 24'h0;
            cmd_rdy_q    <= 1'b0;
            rx_clr_rdy_q <= 1'b0;
            frame_err_q  <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            rx_clr_rdy_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    to_cnt_q <= '0;
                    if (accept) begin
                        cmd_q[23:16] <= rx_data;
                        rx_clr_rdy_q <= 1'b1;
                        state_q      <= B1;
                    end
                end
                B1: begin
                    // A byte on the timeout edge takes priority over the drop.
                    if (accept) begin
                        cmd_q[15:8]  <= rx_data;
                        rx_clr_rdy_q <= 1'b1;
                        to_cnt_q     <= '0;
                        state_q      <= B2;
                    end else if (to_cnt_q == TO_LAST) begin
                        frame_err_q <= 1'b1;
                        to_cnt_q    <= '0;
                        state_q     <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                B2: begin
                    if (accept) begin
                        cmd_q[7:0]   <= rx_data;
                        rx_clr_rdy_q <= 1'b1;
                        cmd_rdy_q    <= 1'b1;
                        to_cnt_q     <= '0;
                        state_q      <= FULL;
                    end else if (to_cnt_q == TO_LAST) begin
                        frame_err_q <= 1'b1;
                        to_cnt_q    <= '0;
                        state_q     <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                FULL: begin
                    // Incoming bytes stay pending in the UART until consumed.
                    to_cnt_q <= '0;
                    if (clr_cmd_rdy) begin
                        cmd_rdy_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign rx_clr_rdy = rx_clr_rdy_q;
    assign frame_err  = frame_err_q;

    resp_tx_ctrl u_tx (
        .clk       (clk),
        .rst       (rst),
        .resp_data (resp_data),
        .send_resp (send_resp),
        .tx_data   (tx_data),
        .trmt      (trmt),
        .tx_done   (tx_done),
        .resp_busy (resp_busy),
        .resp_sent (resp_sent)
    );

endmodule

// File: tb/tb_uart_cmd_frm.sv
module tb_uart_cmd_frm;
    import dso_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_rdy = 1'b0;
    logic        rx_clr_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp_data = 8'h00;
    logic        send_resp = 1'b0;
    logic [7:0]  tx_data;
    logic        trmt;
    logic        tx_done = 1'b0;
    logic        resp_busy;
    logic        resp_sent;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;
    int fe_cnt = 0;
    int trmt_cnt = 0;
    int sent_cnt = 0;
    int trmt_before = 0;

    uart_cmd_frm #(.TO_CYCLES(64), .TO_W(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .rx_clr_rdy  (rx_clr_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp_data   (resp_data),
        .send_resp   (send_resp),
        .tx_data     (tx_data),
        .trmt        (trmt),
        .tx_done     (tx_done),
        .resp_busy   (resp_busy),
        .resp_sent   (resp_sent),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_clr_rdy) clr_cnt  <= clr_cnt + 1;
            if (frame_err)  fe_cnt   <= fe_cnt + 1;
            if (trmt)       trmt_cnt <= trmt_cnt + 1;
            if (resp_sent)  sent_cnt <= sent_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        rx_data = b;
        rx_rdy  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_clr_rdy && n < 200);
        chk("rx_ack_seen", rx_clr_rdy === 1'b1);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic consume();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        int n;
        #12;
        chk("rst_clr",  rx_clr_rdy === 1'b0);
        chk("rst_cmd",  cmd === 24'h0);
        chk("rst_rdy",  cmd_rdy === 1'b0);
        chk("rst_trmt", trmt === 1'b0);
        chk("rst_busy", resp_busy === 1'b0);
        chk("rst_sent", resp_sent === 1'b0);
        chk("rst_ferr", frame_err === 1'b0);
        chk("rst_txd",  tx_data === 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        send_byte(8'h02, 2);
        send_byte(8'h1C, 2);
        send_byte(8'h00, 0);
        @(negedge clk);
        chk("f1_cmd",  cmd === 24'h021C00);
        chk("f1_rdy",  cmd_rdy === 1'b1);
        chk("f1_clrs", clr_cnt == 3);
        chk("f1_op",   opcode_known(cmd[23:16]) === 1'b1);

        tick();
        rx_data = 8'h09;
        rx_rdy  = 1'b1;
        repeat (5) @(negedge clk);
        chk("full_noack", clr_cnt == 3);
        chk("full_cmd",   cmd === 24'h021C00);
        chk("full_rdy",   cmd_rdy === 1'b1);
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        chk("clr_rdy0",      cmd_rdy === 1'b0);
        chk("clr_cmd_hold",  cmd === 24'h021C00);
        chk("clr_noack_yet", rx_clr_rdy === 1'b0);
        @(negedge clk);
        chk("pend_cap", cmd === 24'h091C00);
        chk("pend_ack", rx_clr_rdy === 1'b1);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;

        repeat (70) tick();
        chk("to1_ferr", fe_cnt == 1);
        chk("to1_rdy",  cmd_rdy === 1'b0);
        send_byte(8'h08, 2);
        send_byte(8'h2A, 0);
        repeat (69) tick();
        chk("to2_ferr", fe_cnt == 2);
        chk("to2_cmd",  cmd === 24'h082A00);
        send_byte(8'h03, 2);
        send_byte(8'h00, 2);
        send_byte(8'h80, 0);
        @(negedge clk);
        chk("f2_cmd",  cmd === 24'h030080);
        chk("f2_rdy",  cmd_rdy === 1'b1);
        chk("f2_ferr", fe_cnt == 2);
        tick();
        consume();

        send_byte(8'h04, 62);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        chk("bnd_ferr", fe_cnt == 2);
        chk("bnd_cmd",  cmd === 24'h041122);
        chk("bnd_rdy",  cmd_rdy === 1'b1);
        tick();
        consume();

        send_byte(8'h05, 63);
        send_byte(8'h06, 0);
        @(negedge clk);
        chk("late_ferr", fe_cnt == 3);
        chk("late_cmd",  cmd === 24'h061122);
        chk("late_rdy",  cmd_rdy === 1'b0);
        tick();
        send_byte(8'h07, 0);
        send_byte(8'h08, 0);
        @(negedge clk);
        chk("late_f_cmd", cmd === 24'h060708);
        chk("late_f_rdy", cmd_rdy === 1'b1);
        chk("clr_total",  clr_cnt == 16);
        tick();
        consume();

        resp_data = ACK;
        send_resp = 1'b1;
        tick();
        resp_data = 8'h99;
        @(negedge clk);
        chk("tx_busy",    resp_busy === 1'b1);
        chk("tx_data",    tx_data === 8'hA5);
        chk("tx_trmt_lo", trmt === 1'b0);
        @(posedge clk);
        #1;
        send_resp = 1'b0;
        tx_done   = 1'b1;
        @(negedge clk);
        chk("tx_trmt_hi", trmt === 1'b1);
        chk("tx_drop",    tx_data === 8'hA5);
        @(negedge clk);
        chk("tx_trmt_one",   trmt === 1'b0);
        chk("tx_stale_sent", resp_sent === 1'b0);
        chk("tx_stale_busy", resp_busy === 1'b1);
        @(negedge clk);
        chk("tx_sent", resp_sent === 1'b1);
        chk("tx_idle", resp_busy === 1'b0);
        tick();
        tx_done = 1'b0;
        tick();
        chk("tx_trmt_cnt",  trmt_cnt == 1);
        chk("tx_sent_cnt",  sent_cnt == 1);
        chk("tx_data_keep", tx_data === 8'hA5);

        send_byte(8'h02, 0);
        send_byte(8'h1C, 0);
        resp_data = 8'h5A;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        tick();
        tick();
        trmt_before = trmt_cnt;
        rst = 1'b1;
        #2;
        chk("mr_cmd",  cmd === 24'h0);
        chk("mr_txd",  tx_data === 8'h00);
        chk("mr_busy", resp_busy === 1'b0);
        chk("mr_trmt", trmt === 1'b0);
        chk("mr_rdy",  cmd_rdy === 1'b0);
        chk("mr_clr",  rx_clr_rdy === 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) tick();
        chk("mr_noglitch",   trmt_cnt == trmt_before);
        chk("mr_busy_after", resp_busy === 1'b0);
        send_byte(8'h04, 1);
        send_byte(8'h00, 1);
        send_byte(8'h10, 0);
        @(negedge clk);
        chk("mr_f_cmd", cmd === 24'h040010);
        chk("mr_f_rdy", cmd_rdy === 1'b1);
        tick();

        resp_data = ACK;
        send_resp = 1'b1;
        tick();
        send_resp = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!trmt && n < 20);
        chk("tx2_trmt_seen", trmt === 1'b1);
        @(posedge clk);
        #1;
        tx_done = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_sent && n < 20);
        chk("tx2_sent_seen", resp_sent === 1'b1);
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        chk("tx2_data", tx_data === 8'hA5);
        chk("tx2_busy", resp_busy === 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
